// File: rtl/timetag_pkg.sv
// Shared types and helpers for the timetag host-path serializer.
// Samples are handled as up to 16 bytes; narrower words are zero-extended before byte selection.
package timetag_pkg;

  localparam int SAMPLE_BYTES_DEFAULT = 6;
  localparam int LEN_WIDTH_DEFAULT    = 16;
  localparam int MAX_SAMPLE_BITS      = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // last is the index of the final byte (SAMPLE_BYTES-1); it lets MSB-first order mirror the index.
  function automatic logic [7:0] byte_of(input logic [MAX_SAMPLE_BITS-1:0] word,
                                         input logic [3:0]                 idx,
                                         input logic [3:0]                 last,
                                         input logic                       msb_first);
    logic [3:0] sel;
    sel = msb_first ? (last - idx) : idx;
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sat_readout_counter.sv
// Saturating event counter with read-and-clear snapshot and a sticky overflow flag.
// An increment landing in the same cycle as a readout is folded into the snapshot, so no event is lost.
module sat_readout_counter #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 increment,
  input  logic                 readout_clr,
  output logic [LEN_WIDTH-1:0] count_out,
  output logic                 overflow
);

  logic [LEN_WIDTH-1:0] cnt;
  logic                 sticky;
  logic                 at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sticky    <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else if (readout_clr) begin
      count_out <= (increment && !at_max) ? cnt + 1'b1 : cnt;
      overflow  <= sticky | (increment & at_max);
      cnt       <= '0;
      sticky    <= 1'b0;
    end else if (increment) begin
      if (at_max) sticky <= 1'b1;
      else        cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timetag_serializer.sv
// Pops timetag samples from a show-ahead FIFO and streams them to the host one byte per accept,
// counting delivered samples.  State | meaning:  IDLE | no sample held, data_avail=0
//                                                SEND | presenting byte idx, data_avail=1
module timetag_serializer
  import timetag_pkg::*;
#(
  parameter int SAMPLE_BYTES = SAMPLE_BYTES_DEFAULT,
  parameter int LEN_WIDTH    = LEN_WIDTH_DEFAULT,
  parameter int MSB_FIRST    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_rdy,
  input  logic [8*SAMPLE_BYTES-1:0] sample,
  output logic                      sample_ack,
  output logic                      data_avail,
  output logic [7:0]                data,
  input  logic                      data_accepted,
  input  logic                      abort,
  input  logic                      request_length,
  output logic [LEN_WIDTH-1:0]      length,
  output logic                      overflow
);

  localparam int SW    = 8 * SAMPLE_BYTES;
  localparam int IDX_W = $clog2(SAMPLE_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_BYTES - 1);
  localparam logic [3:0]       LAST_SEL = 4'(SAMPLE_BYTES - 1);
  localparam logic             MSB_SEL  = (MSB_FIRST != 0);

  ser_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             last_accept;

  function automatic logic [MAX_SAMPLE_BITS-1:0] widen(input logic [SW-1:0] v);
    logic [MAX_SAMPLE_BITS-1:0] w;
    w         = '0;
    w[SW-1:0] = v;
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    last_accept = (state_q == SEND) && data_accepted && (idx_q == LAST_IDX);
    sample_ack  = !reset && sample_rdy && !abort && ((state_q == IDLE) || last_accept);

    if (sample_ack) begin
      state_d = SEND;
      idx_d   = '0;
      shreg_d = sample;
      data_d  = byte_of(widen(sample), 4'd0, LAST_SEL, MSB_SEL);
    end else if (state_q == SEND) begin
      // abort wins over a concurrent accept, so an aborted last byte never completes the sample
      if (abort || last_accept) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (data_accepted) begin
        idx_d  = idx_q + 1'b1;
        data_d = byte_of(widen(shreg_q), 4'(idx_d), LAST_SEL, MSB_SEL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
    end
  end

  assign data_avail = (state_q == SEND);
  assign data       = data_q;

  sat_readout_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_len_cnt (
    .clk        (clk),
    .reset      (reset),
    .increment  (last_accept & ~abort),
    .readout_clr(request_length),
    .count_out  (length),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_timetag_serializer.sv
// Bench for timetag_serializer: LSB-first and MSB-first instances share one FIFO model and stimulus;
// a sample scoreboard supplies the expected byte stream, and length readouts are compared to fixed counts.
module tb_timetag_serializer;
  localparam int SB = 6;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_rdy = 1'b0;
  logic [47:0]   sample = '0;
  logic          data_accepted = 1'b1;
  logic          abort = 1'b0;
  logic          request_length = 1'b0;
  logic          ack0, ack1, av0, av1, ov0, ov1;
  logic [7:0]    d0, d1;
  logic [LW-1:0] len0, len1;

  always #5 clk = ~clk;

  timetag_serializer #(.SAMPLE_BYTES(SB), .LEN_WIDTH(LW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .sample_rdy(sample_rdy), .sample(sample), .sample_ack(ack0),
    .data_avail(av0), .data(d0), .data_accepted(data_accepted), .abort(abort),
    .request_length(request_length), .length(len0), .overflow(ov0));

  timetag_serializer #(.SAMPLE_BYTES(SB), .LEN_WIDTH(LW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .sample_rdy(sample_rdy), .sample(sample), .sample_ack(ack1),
    .data_avail(av1), .data(d1), .data_accepted(data_accepted), .abort(abort),
    .request_length(request_length), .length(len1), .overflow(ov1));

  logic [47:0] fifo[$];
  logic [47:0] sb[$];
  int n_total = 0;
  int n_bad = 0;
  int pos = 0;
  int bp_wait = 0;
  int avail_cycles = 0;
  bit exp_avail = 1'b0;
  bit pop_req = 1'b0;
  bit bp_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic refresh();
    sample_rdy = (fifo.size() != 0);
    sample     = sample_rdy ? fifo[0] : '0;
  endtask

  task automatic push(input logic [47:0] s);
    fifo.push_back(s);
    sb.push_back(s);
    refresh();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_req && fifo.size() != 0) void'(fifo.pop_front());
    refresh();
    data_accepted = bp_mode ? (bp_wait == 2) : 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    step();
    while ((sb.size() != 0 || exp_avail) && k < limit) begin
      step();
      k++;
    end
    check("idle_sb_left", sb.size(), 0);
  endtask

  task automatic read_length(input int exp_len, input bit exp_ovf);
    request_length = 1'b1;
    step();
    request_length = 1'b0;
    check("length_lsb", len0, exp_len);
    check("overflow_lsb", ov0, exp_ovf);
    check("length_msb", len1, exp_len);
    check("overflow_msb", ov1, exp_ovf);
  endtask

  // scoreboard monitor: sb[0] is the in-flight sample, pos the bytes of it already accepted
  always @(negedge clk) begin
    if (reset) begin
      pos       = 0;
      exp_avail = 1'b0;
      pop_req   = 1'b0;
      bp_wait   = 0;
    end else begin
      bit          last;
      bit          ack_exp;
      logic [47:0] cur;
      last    = exp_avail && data_accepted && (pos == SB - 1);
      ack_exp = sample_rdy && !abort && (!exp_avail || last);
      check("avail_lsb", av0, exp_avail);
      check("avail_msb", av1, exp_avail);
      check("ack_lsb", ack0, ack_exp);
      check("ack_msb", ack1, ack_exp);
      if (exp_avail) begin
        avail_cycles++;
        cur = (sb.size() != 0) ? sb[0] : 'x;
        check("byte_lsb", d0, cur[8*pos +: 8]);
        check("byte_msb", d1, cur[8*(SB-1-pos) +: 8]);
        if (abort) begin
          if (sb.size() != 0) void'(sb.pop_front());
          pos     = 0;
          bp_wait = 0;
        end else if (data_accepted) begin
          bp_wait = 0;
          if (pos == SB - 1) begin
            if (sb.size() != 0) void'(sb.pop_front());
            pos = 0;
          end else begin
            pos++;
          end
        end else begin
          bp_wait++;
        end
      end
      exp_avail = ack_exp || (exp_avail && !abort && !last);
      pop_req   = ack_exp;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    push(48'h0A0B0C0D0E0F);
    repeat (3) step();
    @(negedge clk);
    check("rst_avail", av0, 0);
    check("rst_data", d0, 0);
    check("rst_length", len0, 0);
    check("rst_overflow", ov0, 0);
    check("rst_ack", ack0, 0);
    check("rst_ack_msb", ack1, 0);
    step();
    reset = 1'b0;

    // single sample, host always ready
    avail_cycles = 0;
    wait_idle(100);
    check("single_cycles", avail_cycles, 6);
    read_length(1, 0);

    // three back-to-back samples
    avail_cycles = 0;
    push(48'h0102_0304_0506);
    push(48'hA1A2_A3A4_A5A6);
    push(48'hF0E1_D2C3_B4A5);
    wait_idle(100);
    check("burst_cycles", avail_cycles, 18);
    read_length(3, 0);

    // backpressure: every byte held three cycles
    bp_mode = 1'b1;
    data_accepted = 1'b0;
    avail_cycles = 0;
    push(48'h1234_5678_9ABC);
    push(48'hDEAD_BEEF_CAFE);
    push(48'h0F1E_2D3C_4B5A);
    wait_idle(300);
    check("bp_cycles", avail_cycles, 54);
    bp_mode = 1'b0;
    read_length(3, 0);

    // abort during byte 3 together with an accept
    push(48'h1112_1314_1516);
    push(48'h2122_2324_2526);
    k = 0;
    while (!(exp_avail && pos == 3) && k < 50) begin
      step();
      k++;
    end
    check("abort_reach_pos", pos, 3);
    abort = 1'b1;
    data_accepted = 1'b1;
    step();
    abort = 1'b0;
    wait_idle(100);
    read_length(1, 0);

    // saturation at LEN_WIDTH=4
    for (int i = 0; i < 17; i++) push(48'({$urandom(), $urandom()}));
    wait_idle(400);
    read_length(15, 1);
    read_length(0, 0);

    // readout coincident with a last-byte accept at cnt=5
    for (int i = 0; i < 5; i++) push(48'({$urandom(), $urandom()}));
    wait_idle(200);
    push(48'h6655_4433_2211);
    k = 0;
    while (!(exp_avail && pos == SB - 1) && k < 50) begin
      step();
      k++;
    end
    check("coinc_reach_pos", pos, SB - 1);
    request_length = 1'b1;
    step();
    request_length = 1'b0;
    check("coinc_length", len0, 6);
    check("coinc_overflow", ov0, 0);
    check("coinc_length_msb", len1, 6);
    wait_idle(50);
    read_length(0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timetag_serializer.md
Name: timetag_serializer

Overview:
- Parametrised successor to the sample byte multiplexer and sample summator pair on the host path.
- Pops fixed-width timetag samples from a show-ahead sample FIFO.
- Serialises each sample into bytes over the data_avail/data_accepted handshake, with configurable byte order and one byte per cycle of throughput.
- Keeps a saturating, readout-and-clear count of delivered samples with a sticky overflow flag, and supports abort of a partially sent sample.

Parameters:
SAMPLE_BYTES, 6, bytes per sample (2..16)
LEN_WIDTH, 16, width of delivered-sample counter
MSB_FIRST, 0, 0 = byte 0 (sample[7:0]) sent first; 1 = most significant byte first

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high reset
sample_rdy  input  1  FIFO not empty; sample valid (show-ahead)
sample  input  8*SAMPLE_BYTES  FIFO head word
sample_ack  output  1  pop strobe to FIFO
data_avail  output  1  byte valid to host interface
data  output  8  current byte
data_accepted  input  1  host consumed byte this cycle
abort  input  1  discard in-flight sample
request_length  input  1  read-and-clear strobe for length
length  output  LEN_WIDTH  delivered-sample count, registered
overflow  output  1  sticky: counter saturated since last readout

Behaviour:
- Reset is synchronous and active-high; one clock.
- Reset values: state IDLE, data_avail=0, data=0, length=0, overflow=0, byte index=0, internal count=0.
- sample_ack is combinational: sample_rdy & ~abort & (state==IDLE | last_accept).
  - last_accept = (state==SEND) & data_avail & data_accepted & (idx==SAMPLE_BYTES-1).
  - sample_ack is never asserted during reset.
- On a sample_ack edge the shift register captures sample, idx<=0, state<=SEND, data_avail<=1. The first byte appears the cycle after the pop.
- States:
  - IDLE: data_avail=0; wait for sample_rdy.
  - SEND: data_avail=1; data = byte idx (MSB_FIRST selects byte SAMPLE_BYTES-1-idx).
- Handshake: data and data_avail are stable until data_accepted. On accept with idx<SAMPLE_BYTES-1, idx increments and the next byte is presented the next cycle. No bubble between bytes or between samples.
- Last-byte accept:
  - If sample_ack is asserted in the same cycle, load the next sample and stay in SEND (back-to-back).
  - Otherwise go to IDLE with data_avail=0.
- Throughput: SAMPLE_BYTES accepted bytes per sample when the host accepts every cycle; no idle cycles between samples while the FIFO is non-empty.
- abort in SEND:
  - Next cycle: IDLE, data_avail=0, idx=0; the sample is not counted; the FIFO is not popped that cycle.
  - abort overrides a concurrent data_accepted (the last byte is not counted).
  - abort in IDLE has no effect beyond suppressing sample_ack that cycle.
- Counter:
  - Internal cnt increments on last_accept & ~abort.
  - At cnt = 2^LEN_WIDTH-1, further increments hold the value and set overflow.
- request_length:
  - length <= cnt (or cnt+1 if an increment occurs the same cycle).
  - cnt <= 0. overflow output <= internal sticky; internal sticky cleared.
  - No completion is lost across a readout.
  - length is stable between request_length strobes.
- Reset mid-sample: the in-flight sample is lost without being counted; FIFO contents are untouched.
- data is X-safe: holds its last value when data_avail=0 (not required to clear).

Decomposition:
- Shared package timetag_pkg holds:
  - constants SAMPLE_BYTES_DEFAULT=6, LEN_WIDTH_DEFAULT=16;
  - serializer state enum {IDLE, SEND};
  - byte-select function byte_of(word, idx, msb_first).
- One sub-module, sat_readout_counter (LEN_WIDTH): increment, readout_clr, count_out, overflow. Reusable in place of the old summator on the detector side.

Test Plan:
- Single sample 48'h0A0B0C0D0E0F, MSB_FIRST=0, host accepts every cycle -> one sample_ack; bytes 0F,0E,0D,0C,0B,0A on 6 consecutive cycles; then data_avail=0. request_length -> length=1.
- Three queued samples, host accepts every cycle -> 18 contiguous bytes with data_avail never dropping; sample_ack pulses on each last-byte cycle. length=3.
- Host backpressure: data_accepted high only every 3rd cycle -> each byte is held stable while waiting. Total 18 cycles per sample at SAMPLE_BYTES=6, with no byte duplicated or skipped.
- abort asserted during byte 3 with data_accepted=1 -> IDLE the next cycle; the next FIFO sample restarts at byte 0. length excludes the aborted sample.
- LEN_WIDTH=4: deliver 17 samples, then request_length -> length=15, overflow=1. A second request_length with no traffic -> length=0, overflow=0.
- request_length coincident with a last-byte accept when cnt=5 -> length=6, and the following readout returns 0. Also run with MSB_FIRST=1 to confirm reversed byte order.
